// File: rtl/input_port_unit.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | input_port_unit : router input port (flit FIFO, XY route, allocator req) |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+

package noc_params;
   localparam int PORT_NUM = 5;
   typedef enum logic [2:0] {
      LOCAL = 3'd0,
      NORTH = 3'd1,
      EAST  = 3'd2,
      SOUTH = 3'd3,
      WEST  = 3'd4
   } port_t;
endpackage

module input_port_unit
   import noc_params::*;
#(
   parameter int FLIT_W       = 16,
   parameter int BUFFER_DEPTH = 4,
   parameter int COORD_W      = 2,
   parameter int X_CUR        = 1,
   parameter int Y_CUR        = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [FLIT_W-1:0]   data_i,
   input  logic                valid_i,
   output logic                credit_o,
   input  logic [PORT_NUM-1:0] credit_avail_i,
   output logic                request_o,
   output port_t               out_port_o,
   input  logic                grant_i,
   output logic [FLIT_W-1:0]   data_o,
   output logic                valid_o,
   output logic                error_o
);

   localparam int PTR_W = $clog2(BUFFER_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]   C_DEPTH    = CNT_W'(BUFFER_DEPTH);
   localparam logic [COORD_W-1:0] C_X_CUR    = COORD_W'(X_CUR);
   localparam logic [COORD_W-1:0] C_Y_CUR    = COORD_W'(Y_CUR);
   localparam logic [1:0]         C_HEAD     = 2'b00;
   localparam logic [1:0]         C_HEADTAIL = 2'b11;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   logic [FLIT_W-1:0] mem_q [BUFFER_DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   state_t            state_q, state_d;
   port_t             out_port_q, out_port_d;
   logic [FLIT_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              credit_q, credit_d;
   logic              error_q, error_d;

   logic [FLIT_W-1:0]  head_flit;
   logic [1:0]         head_type;
   logic [COORD_W-1:0] dest_x, dest_y;
   logic               fifo_empty, fifo_full;
   logic               req, pop, push;
   logic [7:0]         credit_ext;
   port_t              route;

   assign head_flit  = mem_q[rd_ptr_q];
   assign head_type  = head_flit[FLIT_W-1 -: 2];
   assign dest_x     = head_flit[2*COORD_W-1:COORD_W];
   assign dest_y     = head_flit[COORD_W-1:0];
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == C_DEPTH);
   assign credit_ext = 8'(credit_avail_i);
   assign req        = (state_q == ACTIVE) && !fifo_empty && credit_ext[out_port_q];

   // Dimension-ordered routing: resolve X fully before Y.
   always_comb begin
      route = LOCAL;
      if (dest_x > C_X_CUR)      route = EAST;
      else if (dest_x < C_X_CUR) route = WEST;
      else if (dest_y > C_Y_CUR) route = SOUTH;
      else if (dest_y < C_Y_CUR) route = NORTH;
   end

   always_comb begin
      state_d    = state_q;
      out_port_d = out_port_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      credit_d   = 1'b0;
      error_d    = error_q;
      pop        = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               if (head_type == C_HEAD || head_type == C_HEADTAIL) begin
                  out_port_d = route;
                  state_d    = ACTIVE;
               end else begin
                  // Stray body/tail: drop it but still hand the slot back upstream.
                  pop      = 1'b1;
                  credit_d = 1'b1;
                  error_d  = 1'b1;
               end
            end
         end
         ACTIVE: begin
            if (req && grant_i) begin
               pop      = 1'b1;
               data_d   = head_flit;
               valid_d  = 1'b1;
               credit_d = 1'b1;
               if (head_type[1]) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      push = valid_i && (!fifo_full || pop);
      if (valid_i && fifo_full && !pop) error_d = 1'b1;
   end

   always_comb begin
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      count_d  = count_q;
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= data_i;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         state_q    <= IDLE;
         out_port_q <= LOCAL;
         data_q     <= '0;
         valid_q    <= 1'b0;
         credit_q   <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         state_q    <= state_d;
         out_port_q <= out_port_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         credit_q   <= credit_d;
         error_q    <= error_d;
      end
   end

   assign request_o  = req;
   assign out_port_o = out_port_q;
   assign data_o     = data_q;
   assign valid_o    = valid_q;
   assign credit_o   = credit_q;
   assign error_o    = error_q;

endmodule

`default_nettype wire
